decode_execute_unit: RTL and testbench
======================================

// Module: decode_execute_unit
// PURPOSE
// - Decode and execute stage of the 5-stage RV32 pipeline. It merges the instruction decoder, the control unit and the ALU.
// - Combinationally splits the instruction into fields and generates control and immediates. Selects the operands and computes the ALU result, branch decision and jump target.
// - Registers everything into the EX/MEM boundary with 1-cycle latency. Register-file read data arrives in the same cycle as inst.
// PARAMETERS
// - XLEN  32  datapath width (only 32 is supported)
// PORTS
// - clk             in   1   rising-edge clock
// - rst             in   1   synchronous, active-high reset
// - in_valid        in   1   inst/pc/rs*_data are valid this cycle
// - inst            in   32  instruction word
// - pc              in   32  address of inst
// - rs1_data        in   32  register-file read data for rs1
// - rs2_data        in   32  register-file read data for rs2
// - rs1_addr        out  5   inst[19:15], combinational, feeds the register file
// - rs2_addr        out  5   inst[24:20], combinational, feeds the register file
// - out_valid       out  1   registered copy of in_valid
// - out_rd          out  5   destination register
// - out_reg_write   out  1   R, I-arith, load or JAL with rd!=0
// - out_load        out  1   opcode 0000011
// - out_store       out  1   opcode 0100011
// - out_jump        out  1   opcode 1101111 (JAL)
// - out_branch_taken out 1   branch condition true
// - out_result      out  32  ALU result (memory address for load/store)
// - out_target_pc   out  32  pc+offset for a taken branch or JAL, otherwise pc+4
// - out_link        out  32  pc+4 (JAL writeback value)
// - out_store_data  out  32  rs2_data
// - out_illegal     out  1   unsupported opcode or funct combination
// BEHAVIOUR
// - Reset: every registered output is 0 on the clk edge where rst=1. rs1_addr and rs2_addr are not reset.
// - in_valid=0: all control outputs are captured as 0 (bubble). Data outputs may hold any value.
// - Opcodes: R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111. Any other opcode sets illegal=1 with all controls 0.
// - Immediates:
//   - I/LOAD: sext(inst[31:20]).
//   - STORE: sext({inst[31:25],inst[11:7]}).
//   - BRANCH: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
//   - JAL: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
// - Operand A: rs1_data for R/I/LOAD/STORE, pc for BRANCH/JAL, otherwise 0.
// - Operand B: rs2_data for R, the immediate for the others, otherwise 0.
// - alusel (3b): 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA.
// - R-type decode by funct3/funct7[5]:
//   - 000 ADD/SUB, 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL/SRA.
//   - 010/011 (SLT/SLTU) is illegal.
//   - funct7 other than 0000000/0100000 is illegal (0100000 only with 000 or 101).
// - I-type: same table; 000 is always ADD; funct7[5] selects SRAI only for 101.
// - LOAD/STORE/BRANCH/JAL: alusel = ADD.
// - Shifts use operand B[4:0]. SRA is arithmetic. ADD/SUB wrap modulo 2^32.
// - BRANCH: taken when rs1_data==rs2_data and funct3=000 (BEQ). Other funct3 values are never taken unless DEU_FULL_BRANCH_EN is defined.
// - Target: out_target_pc = ALU result when a branch is taken or on JAL, otherwise pc+4.
// - rd=x0: out_reg_write=0.
// - Reset and valid together: rst wins.
// CONFIGURATION
// - DEU_FULL_BRANCH_EN defined: adds BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111 (signed/unsigned compares). funct3 010/011 is illegal.
// - DEU_FULL_BRANCH_EN undefined: only BEQ. Other branch funct3 values are legal, never taken, and produce no writes.
// STRUCTURE
// - deu_pkg: opcode localparams, alusel enum, ctrl_t struct (reg_write, load, store, jump, branch, alusel, illegal), immediate-extract functions.
// - Sub-module deu_alu: purely combinational (a, b, alusel -> result). Decode, control and the output register stay in the top.
// TESTING
// - ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle: result=12, rd=3, reg_write=1.
// - SRAI x5,x1,4 (0x4040D293), rs1=0x80000000 -> result=0xF8000000, reg_write=1.
// - SW x2,8(x1) (0x0020A423), rs1=0x100, rs2=0xAB -> store=1, result=0x108, store_data=0xAB, reg_write=0.
// - BEQ x1,x2,+16 at pc=0x40: equal operands -> branch_taken=1, target=0x50; unequal -> taken=0, target=0x44.
// - JAL x1,+0x800 at pc=0x10 -> jump=1, target=0x810, link=0x14, reg_write=1.
// - Unsupported opcode 0x0000007F -> illegal=1, all controls 0. rst=1 with in_valid=1 -> all outputs 0.

Source files
------------

// File: rtl/deu_pkg.sv
// Shared types, opcodes and immediate helpers for the decode/execute stage.
// Optional feature macro: DEU_FULL_BRANCH_EN (full RV32 branch set).
package deu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alusel_e;

    typedef struct packed {
        logic    reg_write;
        logic    load;
        logic    store;
        logic    jump;
        logic    branch;
        alusel_e alusel;
        logic    illegal;
    } ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        reg_write;
        logic        load;
        logic        store;
        logic        jump;
        logic        branch_taken;
        logic        illegal;
        logic [31:0] result;
        logic [31:0] target_pc;
        logic [31:0] link;
        logic [31:0] store_data;
    } ex_mem_t;

    function automatic logic [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] i);
        return {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // alt picks SUB for 000 and SRA for 101; 010/011 fall back to ADD
    function automatic alusel_e alu_of(input logic [2:0] f3,
                                       input logic alt);
        alusel_e s;
        case (f3)
            3'b000:  s = alt ? ALU_SUB : ALU_ADD;
            3'b111:  s = ALU_AND;
            3'b110:  s = ALU_OR;
            3'b100:  s = ALU_XOR;
            3'b001:  s = ALU_SLL;
            3'b101:  s = alt ? ALU_SRA : ALU_SRL;
            default: s = ALU_ADD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/deu_alu.sv
// Combinational ALU for the decode/execute stage.
// Shifts use b[4:0]; add/sub wrap modulo 2^32.
module deu_alu
    import deu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alusel_e     alusel,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (alusel)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << b[4:0];
            ALU_SRL: result = a >> b[4:0];
            ALU_SRA: result = $unsigned($signed(a) >>> b[4:0]);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/decode_execute_unit.sv
// RV32 decode + execute stage, registered into the EX/MEM boundary.
// Optional feature macro: DEU_FULL_BRANCH_EN (BNE/BLT/BGE/BLTU/BGEU).
module decode_execute_unit
    import deu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic            out_valid,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_load,
    output logic            out_store,
    output logic            out_jump,
    output logic            out_branch_taken,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_target_pc,
    output logic [XLEN-1:0] out_link,
    output logic [XLEN-1:0] out_store_data,
    output logic            out_illegal
);

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            f7_ok;
    ctrl_t           ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] pc_plus4;
    logic            eq;
    logic            cond;
    logic            redirect;
    ex_mem_t         ex_d;
    ex_mem_t         ex_q;

    assign opcode   = inst[6:0];
    assign rd       = inst[11:7];
    assign funct3   = inst[14:12];
    assign funct7   = inst[31:25];
    assign rs1_addr = inst[19:15];
    assign rs2_addr = inst[24:20];
    assign pc_plus4 = pc + XLEN'(4);
    assign eq       = (rs1_data == rs2_data);

    // 0100000 is only meaningful for SUB and SRA
    assign f7_ok = (funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) &&
                    ((funct3 == 3'b000) || (funct3 == 3'b101)));

    always_comb begin
        ctrl        = '0;
        ctrl.alusel = ALU_ADD;
        op_a        = '0;
        op_b        = '0;
        cond        = 1'b0;
        unique case (1'b1)
            opcode == OP_R: begin
                op_a           = rs1_data;
                op_b           = rs2_data;
                ctrl.reg_write = 1'b1;
                ctrl.alusel    = alu_of(funct3, funct7[5]);
                ctrl.illegal   = (funct3[2:1] == 2'b01) || !f7_ok;
            end
            opcode == OP_I: begin
                op_a           = rs1_data;
                op_b           = imm_i(inst);
                ctrl.reg_write = 1'b1;
                ctrl.alusel    = alu_of(funct3,
                                        funct7[5] && (funct3 == 3'b101));
                ctrl.illegal   = (funct3[2:1] == 2'b01);
            end
            opcode == OP_LOAD: begin
                op_a           = rs1_data;
                op_b           = imm_i(inst);
                ctrl.reg_write = 1'b1;
                ctrl.load      = 1'b1;
            end
            opcode == OP_STORE: begin
                op_a       = rs1_data;
                op_b       = imm_s(inst);
                ctrl.store = 1'b1;
            end
            opcode == OP_BRANCH: begin
                op_a        = pc;
                op_b        = imm_b(inst);
                ctrl.branch = 1'b1;
`ifdef DEU_FULL_BRANCH_EN
                case (funct3)
                    3'b000:  cond = eq;
                    3'b001:  cond = !eq;
                    3'b100:  cond = $signed(rs1_data) < $signed(rs2_data);
                    3'b101:  cond = $signed(rs1_data) >= $signed(rs2_data);
                    3'b110:  cond = rs1_data < rs2_data;
                    3'b111:  cond = rs1_data >= rs2_data;
                    default: ctrl.illegal = 1'b1;
                endcase
`else
                cond = eq && (funct3 == 3'b000);
`endif
            end
            opcode == OP_JAL: begin
                op_a           = pc;
                op_b           = imm_j(inst);
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    deu_alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .alusel (ctrl.alusel),
        .result (alu_res)
    );

    assign redirect = !ctrl.illegal &&
                      ((ctrl.branch && cond) || ctrl.jump);

    always_comb begin
        ex_d              = '0;
        ex_d.valid        = in_valid;
        ex_d.rd           = rd;
        ex_d.result       = alu_res;
        ex_d.target_pc    = redirect ? alu_res : pc_plus4;
        ex_d.link         = pc_plus4;
        ex_d.store_data   = rs2_data;
        // bubbles and illegal instructions must not cause side effects
        if (in_valid) begin
            ex_d.illegal      = ctrl.illegal;
            ex_d.reg_write    = !ctrl.illegal && ctrl.reg_write &&
                                (rd != 5'd0);
            ex_d.load         = !ctrl.illegal && ctrl.load;
            ex_d.store        = !ctrl.illegal && ctrl.store;
            ex_d.jump         = !ctrl.illegal && ctrl.jump;
            ex_d.branch_taken = !ctrl.illegal && ctrl.branch && cond;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign out_valid        = ex_q.valid;
    assign out_rd           = ex_q.rd;
    assign out_reg_write    = ex_q.reg_write;
    assign out_load         = ex_q.load;
    assign out_store        = ex_q.store;
    assign out_jump         = ex_q.jump;
    assign out_branch_taken = ex_q.branch_taken;
    assign out_illegal      = ex_q.illegal;
    assign out_result       = ex_q.result;
    assign out_target_pc    = ex_q.target_pc;
    assign out_link         = ex_q.link;
    assign out_store_data   = ex_q.store_data;

endmodule

// File: tb/tb_decode_execute_unit.sv
// Scoreboard bench for decode_execute_unit: directed vectors with
// hand-computed expectations, checked by a decoupled negedge monitor.
module tb_decode_execute_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_load;
    logic        out_store;
    logic        out_jump;
    logic        out_branch_taken;
    logic [31:0] out_result;
    logic [31:0] out_target_pc;
    logic [31:0] out_link;
    logic [31:0] out_store_data;
    logic        out_illegal;

    // ctl packing: {reg_write, load, store, jump, taken, illegal}
    typedef struct {
        string       name;
        logic [4:0]  rd;
        logic [5:0]  ctl;
        logic [31:0] res;
        logic [31:0] tgt;
        logic [31:0] lnk;
        logic [31:0] sd;
        bit          chk_data;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    decode_execute_unit dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .inst             (inst),
        .pc               (pc),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .out_valid        (out_valid),
        .out_rd           (out_rd),
        .out_reg_write    (out_reg_write),
        .out_load         (out_load),
        .out_store        (out_store),
        .out_jump         (out_jump),
        .out_branch_taken (out_branch_taken),
        .out_result       (out_result),
        .out_target_pc    (out_target_pc),
        .out_link         (out_link),
        .out_store_data   (out_store_data),
        .out_illegal      (out_illegal)
    );

    always #5 clk = ~clk;

    logic [5:0] act_ctl;
    assign act_ctl = {out_reg_write, out_load, out_store, out_jump,
                      out_branch_taken, out_illegal};

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got rd=%0d ctl=%b, none expected",
                         out_rd, act_ctl);
            end else begin
                e = sbq.pop_front();
                if (out_rd !== e.rd || act_ctl !== e.ctl ||
                    (e.chk_data &&
                     (out_result !== e.res || out_target_pc !== e.tgt ||
                      out_link !== e.lnk || out_store_data !== e.sd))) begin
                    errors++;
                    $display("FAIL %s: got rd=%0d ctl=%b res=%h tgt=%h lnk=%h sd=%h, expected rd=%0d ctl=%b res=%h tgt=%h lnk=%h sd=%h",
                             e.name, out_rd, act_ctl, out_result,
                             out_target_pc, out_link, out_store_data,
                             e.rd, e.ctl, e.res, e.tgt, e.lnk, e.sd);
                end
            end
        end else if (!rst) begin
            checks++;
            if (act_ctl !== 6'b0) begin
                errors++;
                $display("FAIL bubble_ctl: got ctl=%b, expected 000000",
                         act_ctl);
            end
        end
    end

    task automatic check_zero(input string nm);
        checks++;
        if ({out_valid, out_rd, act_ctl, out_result, out_target_pc,
             out_link, out_store_data} !== '0) begin
            errors++;
            $display("FAIL %s: got valid=%b rd=%0d ctl=%b res=%h tgt=%h, expected all zero",
                     nm, out_valid, out_rd, act_ctl, out_result,
                     out_target_pc);
        end
    endtask

    task automatic issue(input string nm, input logic [31:0] i,
                         input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [5:0] ctl, input logic [31:0] res,
                         input logic [31:0] tgt, input bit chk);
        exp_t e;
        in_valid = 1'b1;
        inst     = i;
        pc       = p;
        rs1_data = a;
        rs2_data = b;
        e = '{nm, rd, ctl, res, tgt, p + 32'd4, b, chk};
        sbq.push_back(e);
        #1;
        checks++;
        if (rs1_addr !== i[19:15] || rs2_addr !== i[24:20]) begin
            errors++;
            $display("FAIL %s_addr: got rs1=%0d rs2=%0d, expected rs1=%0d rs2=%0d",
                     nm, rs1_addr, rs2_addr, i[19:15], i[24:20]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wait_cyc;
        rst      = 1'b1;
        in_valid = 1'b0;
        inst     = '0;
        pc       = '0;
        rs1_data = '0;
        rs2_data = '0;
        @(posedge clk);
        #1;
        check_zero("reset_state");
        in_valid = 1'b1;
        inst     = 32'h002081B3;
        rs1_data = 32'd5;
        rs2_data = 32'd7;
        pc       = 32'h40;
        @(posedge clk);
        #1;
        check_zero("rst_wins_over_valid");
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        issue("add", 32'h002081B3, 32'h0, 32'd5, 32'd7, 5'd3,
              6'b100000, 32'd12, 32'h4, 1);
        issue("sub_wrap", 32'h402081B3, 32'h4, 32'd5, 32'd7, 5'd3,
              6'b100000, 32'hFFFFFFFE, 32'h8, 1);
        issue("srai", 32'h4040D293, 32'h8, 32'h80000000, 32'h0, 5'd5,
              6'b100000, 32'hF8000000, 32'hC, 1);
        issue("sll_b4_0", 32'h002091B3, 32'hC, 32'd1, 32'd35, 5'd3,
              6'b100000, 32'd8, 32'h10, 1);
        issue("and", 32'h0020F1B3, 32'h10, 32'h0000F0F0, 32'h0000FF00,
              5'd3, 6'b100000, 32'h0000F000, 32'h14, 1);
        issue("addi_neg", 32'hFFF00213, 32'h14, 32'h0, 32'h0, 5'd4,
              6'b100000, 32'hFFFFFFFF, 32'h18, 1);
        issue("lw", 32'h0040A303, 32'h18, 32'h200, 32'h0, 5'd6,
              6'b110000, 32'h204, 32'h1C, 1);
        issue("sw", 32'h0020A423, 32'h1C, 32'h100, 32'hAB, 5'd8,
              6'b001000, 32'h108, 32'h20, 1);
        issue("beq_taken", 32'h00208863, 32'h40, 32'd9, 32'd9, 5'd16,
              6'b000010, 32'h50, 32'h50, 1);
        issue("beq_not_taken", 32'h00208863, 32'h40, 32'd9, 32'd3, 5'd16,
              6'b000000, 32'h50, 32'h44, 1);
`ifdef DEU_FULL_BRANCH_EN
        issue("bne", 32'h00209863, 32'h40, 32'd1, 32'd2, 5'd16,
              6'b000010, 32'h50, 32'h50, 1);
`else
        issue("bne", 32'h00209863, 32'h40, 32'd1, 32'd2, 5'd16,
              6'b000000, 32'h50, 32'h44, 1);
`endif
        issue("jal", 32'h001000EF, 32'h10, 32'h0, 32'h0, 5'd1,
              6'b100100, 32'h810, 32'h810, 1);
        issue("jal_x0", 32'h0000006F, 32'h20, 32'h0, 32'h0, 5'd0,
              6'b000100, 32'h20, 32'h20, 1);
        issue("bad_opcode", 32'h0000007F, 32'h80, 32'h0, 32'h0, 5'd0,
              6'b000001, 32'h0, 32'h84, 1);
        issue("slt_illegal", 32'h0020A1B3, 32'h84, 32'd1, 32'd2, 5'd3,
              6'b000001, 32'h0, 32'h0, 0);
        issue("mul_illegal", 32'h022081B3, 32'h88, 32'd1, 32'd2, 5'd3,
              6'b000001, 32'h0, 32'h0, 0);

        in_valid = 1'b0;
        inst     = 32'h002081B3;
        repeat (2) @(posedge clk);
        #1;
        issue("add_after_bubble", 32'h002081B3, 32'h90, 32'd100,
              32'd23, 5'd3, 6'b100000, 32'd123, 32'h94, 1);
        in_valid = 1'b0;

        wait_cyc = 0;
        while (sbq.size() != 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
